mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Sequences data-memory accesses for the load/store instruction held in the EX/MEM pipeline register.
- Drives a req/ready memory port with word-aligned address, byte enables and lane-replicated store data.
- Stalls the front of the pipeline, including the EX/MEM register, until the access completes.
- Returns aligned, sign- or zero-extended load data with its destination register for write-back and forwarding.

Parameters:
TIMEOUT_CYCLES, 64, max cycles in REQ waiting for Mem_Ready before abort (>=1)
CNT_W, 7, counter width; must hold TIMEOUT_CYCLES

Ports:
Clk  in  1  clock, rising edge
Reset_n  in  1  asynchronous, active-low reset
I_Type_Load_MEM  in  1  MEM-stage instruction is a load
S_Type_MEM  in  1  MEM-stage instruction is a store
Func3_MEM  in  3  access size/sign
Address_MEM  in  32  effective byte address (ALU output)
Store_Data_MEM  in  32  rs2 value for stores
rd_MEM  in  5  load destination
Mem_Req  out  1  memory request
Mem_We  out  1  1 = write
Mem_Addr  out  32  {Address_MEM[31:2],2'b00}
Mem_Be  out  4  byte enables
Mem_Wdata  out  32  store data, lane-replicated
Mem_Rdata  in  32  read word, valid with Mem_Ready
Mem_Ready  in  1  access complete
Stall_Pipe  out  1  hold PC, IF/ID, ID/EX, EX/MEM registers
Load_Data_WB  out  32  extended load result
Load_Rd_WB  out  5  rd of returned load
Load_Valid  out  1  one-cycle pulse, Load_Data_WB/Load_Rd_WB valid
Access_Err  out  1  one-cycle pulse: misaligned or illegal Func3
Timeout_Err  out  1  sticky until reset

Behaviour:
- Reset (Reset_n=0, async): state IDLE, counter 0.
  - All registered outputs 0: Mem_Req, Mem_We, Mem_Addr, Mem_Be, Mem_Wdata, Load_Data_WB, Load_Rd_WB, Load_Valid, Access_Err, Timeout_Err.
  - Stall_Pipe forced 0.
  - Reset mid-access drops Mem_Req immediately; the access is abandoned.
- Access valid = I_Type_Load_MEM | S_Type_MEM. If both are high, treat as store.
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
- IDLE:
  - Valid and legal/aligned: Stall_Pipe=1 combinationally this cycle. Register Mem_Addr, Mem_We, Mem_Be, Mem_Wdata, Func3, addr[1:0] and rd. Mem_Req=1 from the next edge. Go to REQ.
  - Valid and illegal/misaligned: no request, no stall. Access_Err=1 next cycle for one cycle. Stay IDLE.
- REQ:
  - Stall_Pipe=1. Mem_Req and request fields held stable. Counter increments each cycle.
  - Mem_Ready=1: Mem_Req deasserts at the next edge. For loads, register the extracted data. Go to DONE.
  - Counter reaches TIMEOUT_CYCLES-1 without ready: drop Mem_Req, set Timeout_Err, go to DONE with no load result.
- DONE:
  - Stall_Pipe=0 so EX/MEM advances at the end of this cycle.
  - Load_Valid=1 for completed loads only (not stores, not timeouts).
  - Inputs in DONE are ignored (same instruction still present). Next state IDLE unconditionally.
- Minimum cost per access with zero-wait memory: 3 cycles (IDLE stall, REQ, DONE). Back-to-back accesses have no extra bubble.
- Mem_Ready is ignored when Mem_Req=0.
- Byte enables and store data:
  - SB: Mem_Be=4'b0001<<addr[1:0], Mem_Wdata={4{data[7:0]}}.
  - SH: Mem_Be=4'b0011<<{addr[1],1'b0}, Mem_Wdata={2{data[15:0]}}.
  - SW: Mem_Be=4'b1111.
  - Loads drive Mem_Be per size and Mem_Wdata=0.
- Load extract: select byte Rdata[8*addr[1:0]+:8] or halfword Rdata[16*addr[1]+:16]. LB/LH sign-extend; LBU/LHU zero-extend.
- Load_Data_WB and Load_Rd_WB hold their values until the next load completes.

Test Plan:
- LW addr 0x100, Mem_Ready 2 cycles after Mem_Req -> Mem_Addr 0x100, Be 1111, Stall_Pipe high 4 cycles, Load_Valid one cycle, data = Mem_Rdata.
- LB addr 0x203, Rdata 0x80123456, immediate ready -> Be 1000, Load_Data_WB 0xFFFFFF80. LBU same -> 0x00000080.
- SH addr 0x302, data 0x1234ABCD -> Mem_We 1, Be 1100, Wdata 0xABCDABCD, Load_Valid stays 0.
- LW addr 0x102, or Func3 011 -> no Mem_Req, no stall, Access_Err single-cycle pulse.
- Ready never asserted, TIMEOUT_CYCLES=4 -> Mem_Req 4 cycles then drops, Timeout_Err 1 (sticky), Stall_Pipe released in DONE, Load_Valid 0.
- Reset_n low while in REQ -> Mem_Req and Stall_Pipe 0 immediately; after release, next load completes normally.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Data-memory port between the load/store controller (master) and the memory (slave).
// Handshake: master holds Mem_Req and all request fields stable until it samples Mem_Ready=1.
interface mem_access_ctrl_if;
    logic        Mem_Req;
    logic        Mem_We;
    logic [31:0] Mem_Addr;
    logic [3:0]  Mem_Be;
    logic [31:0] Mem_Wdata;
    logic [31:0] Mem_Rdata;
    logic        Mem_Ready;

    modport master (
        output Mem_Req, Mem_We, Mem_Addr, Mem_Be, Mem_Wdata,
        input  Mem_Rdata, Mem_Ready
    );

    modport slave (
        input  Mem_Req, Mem_We, Mem_Addr, Mem_Be, Mem_Wdata,
        output Mem_Rdata, Mem_Ready
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Sequences the MEM-stage load/store onto a req/ready memory port, stalling the
// pipeline front until the access completes, and returns extended load data.
module mem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic                      I_Type_Load_MEM,
    input  logic                      S_Type_MEM,
    input  logic [2:0]                Func3_MEM,
    input  logic [31:0]               Address_MEM,
    input  logic [31:0]               Store_Data_MEM,
    input  logic [4:0]                rd_MEM,
    mem_access_ctrl_if.master         mem,
    output logic                      Stall_Pipe,
    output logic [31:0]               Load_Data_WB,
    output logic [4:0]                Load_Rd_WB,
    output logic                      Load_Valid,
    output logic                      Access_Err,
    output logic                      Timeout_Err,
    output logic [1:0]                State_Dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [3:0]       mem_be_q, mem_be_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic [2:0]       func3_q, func3_d;
    logic [1:0]       off_q, off_d;
    logic [4:0]       rd_q, rd_d;
    logic [31:0]      ld_data_q, ld_data_d;
    logic [4:0]       ld_rd_q, ld_rd_d;
    logic             ld_valid_q, ld_valid_d;
    logic             acc_err_q, acc_err_d;
    logic             to_err_q, to_err_d;

    logic        access_vld;
    logic        is_store;
    logic        legal;
    logic        misalign;
    logic        start;
    logic        bad;
    logic        ready_hit;
    logic        timeout_hit;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] ld_ext;

    // Decode of the instruction currently sitting in EX/MEM; store wins if both flags are set.
    always_comb begin
        access_vld = I_Type_Load_MEM | S_Type_MEM;
        is_store   = S_Type_MEM;
        if (is_store) begin
            legal = (Func3_MEM == 3'b000) || (Func3_MEM == 3'b001) || (Func3_MEM == 3'b010);
        end else begin
            legal = (Func3_MEM == 3'b000) || (Func3_MEM == 3'b001) || (Func3_MEM == 3'b010) ||
                    (Func3_MEM == 3'b100) || (Func3_MEM == 3'b101);
        end
        misalign = ((Func3_MEM[1:0] == 2'b01) && Address_MEM[0]) ||
                   ((Func3_MEM[1:0] == 2'b10) && (Address_MEM[1:0] != 2'b00));
        start = (state_q == S_IDLE) && access_vld && legal && !misalign;
        bad   = (state_q == S_IDLE) && access_vld && !(legal && !misalign);

        case (Func3_MEM[1:0])
            2'b00:   be_new = 4'b0001 << Address_MEM[1:0];
            2'b01:   be_new = 4'b0011 << {Address_MEM[1], 1'b0};
            default: be_new = 4'b1111;
        endcase

        wdata_new = 32'h0;
        if (is_store) begin
            case (Func3_MEM[1:0])
                2'b00:   wdata_new = {4{Store_Data_MEM[7:0]}};
                2'b01:   wdata_new = {2{Store_Data_MEM[15:0]}};
                default: wdata_new = Store_Data_MEM;
            endcase
        end
    end

    always_comb begin
        ready_hit   = mem.Mem_Ready & mem_req_q;
        timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

        case (off_q)
            2'd0:    rd_byte = mem.Mem_Rdata[7:0];
            2'd1:    rd_byte = mem.Mem_Rdata[15:8];
            2'd2:    rd_byte = mem.Mem_Rdata[23:16];
            default: rd_byte = mem.Mem_Rdata[31:24];
        endcase
        rd_half = off_q[1] ? mem.Mem_Rdata[31:16] : mem.Mem_Rdata[15:0];

        case (func3_q)
            3'b000:  ld_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  ld_ext = {{16{rd_half[15]}}, rd_half};
            3'b100:  ld_ext = {24'h0, rd_byte};
            3'b101:  ld_ext = {16'h0, rd_half};
            default: ld_ext = mem.Mem_Rdata;
        endcase
    end

    // FSM: state register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_REQ;
            S_REQ:   if (ready_hit || timeout_hit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs; the IDLE stall is combinational so EX/MEM holds in the issue cycle.
    always_comb begin
        Stall_Pipe = Reset_n && (start || (state_q == S_REQ));
        State_Dbg  = state_q;
    end

    always_comb begin
        cnt_d       = (state_q == S_REQ) ? cnt_q + CNT_W'(1) : '0;
        mem_req_d   = start || ((state_q == S_REQ) && !ready_hit && !timeout_hit);
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        func3_d     = func3_q;
        off_d       = off_q;
        rd_d        = rd_q;
        ld_data_d   = ld_data_q;
        ld_rd_d     = ld_rd_q;
        ld_valid_d  = 1'b0;
        acc_err_d   = bad;
        to_err_d    = to_err_q;

        if (start) begin
            mem_we_d    = is_store;
            mem_addr_d  = {Address_MEM[31:2], 2'b00};
            mem_be_d    = be_new;
            mem_wdata_d = wdata_new;
            func3_d     = Func3_MEM;
            off_d       = Address_MEM[1:0];
            rd_d        = rd_MEM;
        end

        if ((state_q == S_REQ) && ready_hit && !mem_we_q) begin
            ld_valid_d = 1'b1;
            ld_data_d  = ld_ext;
            ld_rd_d    = rd_q;
        end

        if ((state_q == S_REQ) && !ready_hit && timeout_hit) begin
            to_err_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_be_q    <= 4'h0;
            mem_wdata_q <= 32'h0;
            func3_q     <= 3'h0;
            off_q       <= 2'h0;
            rd_q        <= 5'h0;
            ld_data_q   <= 32'h0;
            ld_rd_q     <= 5'h0;
            ld_valid_q  <= 1'b0;
            acc_err_q   <= 1'b0;
            to_err_q    <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            func3_q     <= func3_d;
            off_q       <= off_d;
            rd_q        <= rd_d;
            ld_data_q   <= ld_data_d;
            ld_rd_q     <= ld_rd_d;
            ld_valid_q  <= ld_valid_d;
            acc_err_q   <= acc_err_d;
            to_err_q    <= to_err_d;
        end
    end

    assign mem.Mem_Req   = mem_req_q;
    assign mem.Mem_We    = mem_we_q;
    assign mem.Mem_Addr  = mem_addr_q;
    assign mem.Mem_Be    = mem_be_q;
    assign mem.Mem_Wdata = mem_wdata_q;
    assign Load_Data_WB  = ld_data_q;
    assign Load_Rd_WB    = ld_rd_q;
    assign Load_Valid    = ld_valid_q;
    assign Access_Err    = acc_err_q;
    assign Timeout_Err   = to_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: stimulus pushes expected requests, load
// results and error pulses into queues; a negedge monitor pops and compares.
module tb_mem_access_ctrl;

    localparam int K_OK  = 0;
    localparam int K_ERR = 1;
    localparam int K_TO  = 2;

    logic        clk;
    logic        rst_n;
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [4:0]  rd;
    logic        stall;
    logic [31:0] load_data;
    logic [4:0]  load_rd;
    logic        load_valid;
    logic        access_err;
    logic        timeout_err;
    logic [1:0]  state_dbg;

    mem_access_ctrl_if mif ();

    mem_access_ctrl #(
        .TIMEOUT_CYCLES (4),
        .CNT_W          (3)
    ) dut (
        .Clk             (clk),
        .Reset_n         (rst_n),
        .I_Type_Load_MEM (ld),
        .S_Type_MEM      (st),
        .Func3_MEM       (f3),
        .Address_MEM     (addr),
        .Store_Data_MEM  (sdata),
        .rd_MEM          (rd),
        .mem             (mif),
        .Stall_Pipe      (stall),
        .Load_Data_WB    (load_data),
        .Load_Rd_WB      (load_rd),
        .Load_Valid      (load_valid),
        .Access_Err      (access_err),
        .Timeout_Err     (timeout_err),
        .State_Dbg       (state_dbg)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard state
    logic [68:0] exp_req_q[$];
    logic [36:0] exp_load_q[$];
    logic [0:0]  exp_err_q[$];
    int chk_cnt  = 0;
    int pass_cnt = 0;

    int          mem_lat   = -1;
    logic [31:0] mem_rdata = 32'h0;

    task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Memory responder: asserts ready mem_lat cycles into a request; mem_lat<0 never responds.
    initial begin
        int wait_cnt;
        wait_cnt      = 0;
        mif.Mem_Ready = 1'b0;
        mif.Mem_Rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (mif.Mem_Req) begin
                if (mem_lat >= 0 && wait_cnt == mem_lat) begin
                    mif.Mem_Ready = 1'b1;
                    mif.Mem_Rdata = mem_rdata;
                end else begin
                    mif.Mem_Ready = 1'b0;
                    mif.Mem_Rdata = 32'h5A5A5A5A;
                end
                wait_cnt++;
            end else begin
                wait_cnt      = 0;
                mif.Mem_Ready = 1'b0;
            end
        end
    end

    // Monitor
    initial begin
        logic        prev_req;
        logic [68:0] cur_req;
        logic [68:0] act;
        prev_req = 1'b0;
        cur_req  = '0;
        forever begin
            @(negedge clk);
            act = {mif.Mem_We, mif.Mem_Addr, mif.Mem_Be, mif.Mem_Wdata};
            if (mif.Mem_Req && !prev_req) begin
                if (exp_req_q.size() == 0) check("req_unexpected", 69'd1, 69'd0);
                else begin
                    cur_req = exp_req_q.pop_front();
                    check("req_fields", act, cur_req);
                end
            end else if (mif.Mem_Req) begin
                check("req_stable", act, cur_req);
            end
            prev_req = mif.Mem_Req;

            if (load_valid) begin
                if (exp_load_q.size() == 0) check("load_unexpected", 69'd1, 69'd0);
                else check("load_result", {32'h0, load_rd, load_data}, {32'h0, exp_load_q.pop_front()});
            end

            if (access_err) begin
                if (exp_err_q.size() == 0) check("err_unexpected", 69'd1, 69'd0);
                else check("access_err", {68'h0, access_err}, {68'h0, exp_err_q.pop_front()});
            end
        end
    end

    // Driver: presents one instruction in IDLE and counts stall cycles until release.
    task automatic access(input logic i_ld, input logic i_st, input logic [2:0] i_f3,
                          input logic [31:0] i_addr, input logic [31:0] i_sd, input logic [4:0] i_rd,
                          input int lat, input logic [31:0] rdata, input int kind,
                          input logic [3:0] e_be, input logic [31:0] e_wdata,
                          input logic [31:0] e_load, input int e_stall);
        int n;
        @(posedge clk);
        #1;
        ld = i_ld; st = i_st; f3 = i_f3; addr = i_addr; sdata = i_sd; rd = i_rd;
        mem_lat   = lat;
        mem_rdata = rdata;
        if (kind == K_ERR) begin
            exp_err_q.push_back(1'b1);
        end else begin
            exp_req_q.push_back({i_st, i_addr[31:2], 2'b00, e_be, e_wdata});
            if (i_ld && !i_st && kind == K_OK) exp_load_q.push_back({i_rd, e_load});
        end
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (stall) n++;
            else break;
        end
        check("stall_cycles", 69'(n), 69'(e_stall));
    endtask

    task automatic idle(input int cycles);
        @(posedge clk);
        #1;
        ld = 1'b0; st = 1'b0;
        repeat (cycles) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        ld = 1'b1; st = 1'b0; f3 = 3'b010; addr = 32'h0; sdata = 32'h0; rd = 5'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req",     {68'h0, mif.Mem_Req}, 69'd0);
        check("rst_fields",  {mif.Mem_We, mif.Mem_Addr, mif.Mem_Be, mif.Mem_Wdata}, 69'd0);
        check("rst_load",    {32'h0, load_rd, load_data}, 69'd0);
        check("rst_pulses",  {66'h0, load_valid, access_err, timeout_err}, 69'd0);
        check("rst_stall",   {68'h0, stall}, 69'd0);
        check("rst_state",   {67'h0, state_dbg}, 69'd0);
        ld = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        //       ld    st    f3      addr          sdata         rd  lat rdata         kind   be       wdata         load          stall
        access(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0,        5'd5, 2, 32'hDEADBEEF, K_OK, 4'b1111, 32'h0,        32'hDEADBEEF, 4);
        access(1'b1, 1'b0, 3'b000, 32'h0000_0203, 32'h0,        5'd6, 0, 32'h80123456, K_OK, 4'b1000, 32'h0,        32'hFFFFFF80, 2);
        access(1'b1, 1'b0, 3'b100, 32'h0000_0203, 32'h0,        5'd7, 0, 32'h80123456, K_OK, 4'b1000, 32'h0,        32'h00000080, 2);
        access(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0,        5'd8, 1, 32'h80017FFF, K_OK, 4'b1100, 32'h0,        32'hFFFF8001, 3);
        access(1'b1, 1'b0, 3'b101, 32'h0000_0100, 32'h0,        5'd9, 0, 32'h80017FFF, K_OK, 4'b0011, 32'h0,        32'h00007FFF, 2);
        access(1'b0, 1'b1, 3'b001, 32'h0000_0302, 32'h1234ABCD, 5'd1, 1, 32'h0,        K_OK, 4'b1100, 32'hABCDABCD, 32'h0,        3);
        check("load_hold", {32'h0, load_rd, load_data}, {32'h0, 5'd9, 32'h00007FFF});
        access(1'b0, 1'b1, 3'b000, 32'h0000_0401, 32'h000000A5, 5'd2, 0, 32'h0,        K_OK, 4'b0010, 32'hA5A5A5A5, 32'h0,        2);
        access(1'b1, 1'b1, 3'b010, 32'h0000_0500, 32'hCAFEF00D, 5'd3, 0, 32'h0,        K_OK, 4'b1111, 32'hCAFEF00D, 32'h0,        2);
        access(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0,        5'd4, 0, 32'h0,        K_ERR, 4'b0,   32'h0,        32'h0,        0);
        access(1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0,        5'd4, 0, 32'h0,        K_ERR, 4'b0,   32'h0,        32'h0,        0);
        access(1'b0, 1'b1, 3'b001, 32'h0000_0301, 32'h0,        5'd4, 0, 32'h0,        K_ERR, 4'b0,   32'h0,        32'h0,        0);
        access(1'b0, 1'b1, 3'b100, 32'h0000_0300, 32'h0,        5'd4, 0, 32'h0,        K_ERR, 4'b0,   32'h0,        32'h0,        0);
        idle(2);
        check("no_timeout_yet", {68'h0, timeout_err}, 69'd0);

        access(1'b1, 1'b0, 3'b010, 32'h0000_0600, 32'h0,        5'd10, -1, 32'h0,      K_TO, 4'b1111, 32'h0,        32'h0,        5);
        check("timeout_set", {68'h0, timeout_err}, 69'd1);
        idle(3);
        @(negedge clk);
        check("timeout_sticky", {68'h0, timeout_err}, 69'd1);

        // Reset while the request is outstanding
        @(posedge clk);
        #1;
        ld = 1'b1; st = 1'b0; f3 = 3'b010; addr = 32'h0000_0700; rd = 5'd11;
        mem_lat = -1;
        exp_req_q.push_back({1'b0, 32'h0000_0700, 4'b1111, 32'h0});
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_req",   {68'h0, mif.Mem_Req}, 69'd0);
        check("rst_mid_stall", {68'h0, stall}, 69'd0);
        check("rst_mid_state", {66'h0, state_dbg, timeout_err}, 69'd0);
        ld = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        access(1'b1, 1'b0, 3'b010, 32'h0000_0104, 32'h0,        5'd31, 0, 32'h11223344, K_OK, 4'b1111, 32'h0,       32'h11223344, 2);
        idle(4);
        check("exp_req_left",  69'(exp_req_q.size()), 69'd0);
        check("exp_load_left", 69'(exp_load_q.size()), 69'd0);
        check("exp_err_left",  69'(exp_err_q.size()), 69'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
